dmem_responder: RTL and testbench

Handshaked data-memory responder for the pipelined RISC-V core. It is the target end of the core's Memory-stage load/store port. It accepts one request at a time, holds it for a fixed, parameterised access latency, then commits the store or returns the load word with a one-cycle response strobe. It replaces the zero-wait-state data memory so that the core's stall logic can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, fixed LATENCY, one-cycle response pulse.
// Optional DMEM_MISALIGN_ERR_EN: flag accesses with req_addr[1:0] != 0 as errors.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_reg;
    logic [3:0]     cnt_reg;
    logic           we_reg;
    logic [31:0]    addr_reg;
    logic [31:0]    wdata_reg;
    logic [3:0]     be_reg;

    logic [AW-1:0]  req_idx;
    logic [AW-1:0]  idx;
    logic [31:0]    rd_word;
    logic           out_of_range;
    logic           misalign;
    logic           access_err;
    logic           commit;

    assign req_idx = req_addr[AW+1:2];
    assign idx     = addr_reg[AW+1:2];

    // DEPTH_WORDS is a power of two, so any set bit above the index field is out of range.
    assign out_of_range = |addr_reg[31:AW+2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = |addr_reg[1:0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_reg[1:0];
    assign misalign = 1'b0;
`endif

    assign access_err = out_of_range | misalign;
    assign commit     = (state_reg == WAIT) && (cnt_reg == 4'd0) && !reset;

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    // One byte-lane RAM per enable bit; the read register follows the request address
    // while idle, so on the accept edge it captures the word this access will return.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (commit && we_reg && !access_err && be_reg[gi]) begin
                    mem[idx] <= wdata_reg[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (state_reg == IDLE) begin
                    rd_byte_reg <= mem[req_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            be_reg    <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
                        cnt_reg   <= 4'(LATENCY - 1);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= access_err;
                        rsp_rdata <= (we_reg || access_err) ? 32'd0 : rd_word;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: edge-arithmetic reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference model: edge n accepts when n >= last_accept + LAT + 2, commits at accept + LAT.
    logic [31:0] mmem [DEPTH];
    int          n = 0;
    int          acc = -100;
    bit          pend = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          exp_valid = 0;
    bit          exp_busy = 0;
    logic [31:0] exp_rdata = 32'd0;
    bit          exp_err = 0;
    int          exp_pulses = 0;
    int          dut_pulses = 0;

    function automatic bit model_err(input logic [31:0] a);
        bit e;
        e = ({2'b00, a[31:2]} >= 32'(DEPTH));
`ifdef DMEM_MISALIGN_ERR_EN
        if (a[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                pend = 0; acc = -100;
                exp_valid = 0; exp_busy = 0; exp_rdata = 32'd0; exp_err = 0;
            end else begin
                n = n + 1;
                exp_valid = 0;
                if (pend && n == acc + LAT) begin
                    int w;
                    w = int'(m_addr >> 2) % DEPTH;
                    exp_err = model_err(m_addr);
                    if (m_we) begin
                        if (!exp_err)
                            for (int b = 0; b < 4; b++)
                                if (m_be[b]) mmem[w][8*b +: 8] = m_wdata[8*b +: 8];
                        exp_rdata = 32'd0;
                    end else begin
                        exp_rdata = exp_err ? 32'd0 : mmem[w];
                    end
                    exp_valid = 1;
                    exp_pulses++;
                    pend = 0;
                end else if (req_valid && n >= acc + LAT + 2) begin
                    pend = 1; acc = n;
                    m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_be = req_be;
                end
                exp_busy = (n >= acc) && (n <= acc + LAT);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                check("req_ready", 32'(req_ready), 32'(!exp_busy));
                check("busy", 32'(busy), 32'(exp_busy));
                check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                if (rsp_valid === 1'b1) dut_pulses++;
            end
        end
    end

    task automatic send(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        bit rdy = 0;
        int k = 0;
        req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        req_valid = 1'b1;
        while (!rdy && k < 50) begin
            @(negedge clk);
            rdy = (req_ready === 1'b1);
            @(posedge clk);
            k++;
        end
        #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
        if (!rdy) begin
            tests++; fails++;
            $display("FAIL send_timeout: addr %h never accepted within 50 cycles", a);
        end
    endtask

    task automatic get_rsp(output logic [31:0] rd, output logic er, output int lat);
        bit got = 0;
        int k = 0;
        rd = 32'd0; er = 1'b0; lat = -1;
        while (!got && k < 40) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1; rd = rsp_rdata; er = rsp_err; lat = cyc - acc_cyc;
            end
            k++;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: no rsp_valid within 40 cycles");
        end
    endtask

    task automatic gap(input int g);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            send(1'b1, 32'(i * 4), 32'hA500_0000 + 32'(i), 4'hF);
            gap(1);
        end

        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        get_rsp(rd, er, lat);
        check("store_latency", 32'(lat), 32'd2);
        check("store_err", 32'(er), 32'd0);
        send(1'b0, 32'h10, 32'd0, 4'h0);
        get_rsp(rd, er, lat);
        check("load_10", rd, 32'hDEAD_BEEF);
        check("load_latency", 32'(lat), 32'd2);

        send(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        get_rsp(rd, er, lat);
        send(1'b0, 32'h10, 32'd0, 4'h0);
        get_rsp(rd, er, lat);
        check("byte_enable", rd, 32'hDE22_BE44);
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        get_rsp(rd, er, lat);

        send(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF);
        get_rsp(rd, er, lat);
        check("range_store_err", 32'(er), 32'd1);
        send(1'b0, 32'h400, 32'd0, 4'h0);
        get_rsp(rd, er, lat);
        check("range_load_err", 32'(er), 32'd1);
        check("range_load_data", rd, 32'd0);
        send(1'b0, 32'h0, 32'd0, 4'h0);
        get_rsp(rd, er, lat);
        check("load_0_data", rd, 32'hA500_0000);
        check("load_0_err", 32'(er), 32'd0);

        // Hold-off: second request held valid from the cycle after the first accept.
        send(1'b0, 32'h10, 32'd0, 4'h0);
        send(1'b0, 32'h20, 32'd0, 4'h0);
        get_rsp(rd, er, lat);
        check("holdoff_data", rd, 32'hA500_0008);

        // Reset abort of a store while in WAIT.
        send(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        gap(1);
        send(1'b0, 32'h10, 32'd0, 4'h0);
        get_rsp(rd, er, lat);
        check("abort_load_10", rd, 32'hDEAD_BEEF);

        send(1'b0, 32'h12, 32'd0, 4'h0);
        get_rsp(rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
        check("misalign_err", 32'(er), 32'd1);
        check("misalign_data", rd, 32'd0);
`else
        check("misalign_err", 32'(er), 32'd0);
        check("misalign_data", rd, 32'hDEAD_BEEF);
`endif

        for (int t = 0; t < 200; t++) begin
            a = 32'($urandom_range(0, 15)) * 32'd4;
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0400;
            send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            gap($urandom_range(0, 3));
        end

        gap(LAT + 4);
        done = 1;
        check("pulse_count", 32'(dut_pulses), 32'(exp_pulses));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
